uc_sequencer: RTL

//  Instruction sequencer of the 8-bit processor; sits directly upstream of the accumulator

---
 rtl/uc_sequencer.sv | 94 +++++++++
 1 files changed

// File: rtl/uc_sequencer.sv
// Instruction sequencer: fetches one byte per instruction over a req/ready handshake,
// decodes it and issues one-cycle execute strobes to the accumulator control block.
module uc_sequencer #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    input  logic              carry,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ir,
    output logic              jump,
    output logic              jumpC,
    output logic              sin,
    output logic              InA,
    output logic              twone,
    output logic              halted
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    localparam logic [3:0] OP_HLT = 4'hF;

    logic [2:0] state;
    logic [3:0] opcode;
    logic [4:0] dec_strb;  // {jump, jumpC, sin, InA, twone}

    assign opcode = ir[DATA_W-1:DATA_W-4];

    always_comb begin
        dec_strb = 5'b00000;
        case (opcode)
            4'h1:       dec_strb = 5'b00010;
            4'h2, 4'h3: dec_strb = 5'b00011;
            4'h5:       dec_strb = 5'b10000;
            4'h6:       dec_strb = 5'b01000;
            4'h7:       dec_strb = 5'b00110;
            default:    dec_strb = 5'b00000;
        endcase
    end

    // Strobes are loaded only on DECODE->EXEC and cleared every other cycle,
    // so each one is high for exactly the single EXEC cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
            pc    <= '0;
            ir    <= '0;
            {jump, jumpC, sin, InA, twone} <= 5'b00000;
        end else begin
            {jump, jumpC, sin, InA, twone} <= 5'b00000;
            case (state)
                S_FETCH: state <= S_WAIT;
                S_WAIT: begin
                    if (mem_ready) begin
                        ir    <= mem_rdata;
                        pc    <= pc + 1'b1;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (opcode == OP_HLT) begin
                        state <= S_HALT;
                    end else begin
                        {jump, jumpC, sin, InA, twone} <= dec_strb;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // Branch target overrides the increment already applied in WAIT.
                    if (jump || (jumpC && carry))
                        pc <= ir[ADDR_W-1:0];
                    state <= S_FETCH;
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

    // Gated by reset so the request drops immediately even though reset parks the FSM in FETCH.
    assign mem_rd   = ((state == S_FETCH) || (state == S_WAIT)) && !reset;
    assign mem_addr = pc;
    assign halted   = (state == S_HALT);

endmodule
